usb_status_transmitter: RTL and testbench

FPGA-to-PC side of the FT245-style USB FIFO link. On a report request it snapshots the four panel-selector nibbles. It then writes four bytes to the FIFO, {cmd, nibble} with cmd 1..4 carrying panel_switches[3:0], [7:4], [11:8], [15:12]. It sits beside the PC-to-FPGA command receiver and shares the bidirectional data bus with it through a request/grant handshake.

---
 rtl/usb_protocol_pkg.sv | 59 +++++
 rtl/rising_edge_detector.sv | 23 ++
 rtl/usb_status_transmitter.sv | 162 ++++++++++++++++
 tb/tb_usb_status_transmitter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_protocol_pkg.sv
// Shared definitions for the FT245-style USB FIFO link: command codes in
// both directions, the status transmitter state encoding and default timing.
package usb_protocol_pkg;

  // PC-to-FPGA command codes (upper nibble of a received byte)
  localparam logic [3:0] CMD_REQUEST_PANEL = 4'd1;
  localparam logic [3:0] CMD_PANEL_ADDR    = 4'd2;
  localparam logic [3:0] CMD_ROW_ADDR      = 4'd3;
  localparam logic [3:0] CMD_CHUNK_ADDR    = 4'd4;
  localparam logic [3:0] CMD_NIBBLE_FIRST  = 4'd5;
  localparam logic [3:0] CMD_NIBBLE_LAST   = 4'd12;
  localparam logic [3:0] CMD_WRITE_CHUNK   = 4'd13;

  // FPGA-to-PC command codes, one per panel selector nibble
  localparam logic [3:0] CMD_PANEL0 = 4'd1;
  localparam logic [3:0] CMD_PANEL1 = 4'd2;
  localparam logic [3:0] CMD_PANEL2 = 4'd3;
  localparam logic [3:0] CMD_PANEL3 = 4'd4;

  // Default FIFO write timing, in clock cycles
  localparam int DEFAULT_SETUP_CYCLES    = 1;
  localparam int DEFAULT_WR_PULSE_CYCLES = 4;
  localparam int DEFAULT_RECOVER_CYCLES  = 3;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_REQ     = 3'd1,
    TX_SETUP   = 3'd2,
    TX_STROBE  = 3'd3,
    TX_HOLD    = 3'd4,
    TX_RECOVER = 3'd5,
    TX_DONE    = 3'd6
  } tx_state_e;

  // Largest of three timing values; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Status byte for one panel: {CMD_PANEL0 + idx, selected nibble}.
  function automatic logic [7:0] panel_byte(input logic [1:0] idx, input logic [15:0] snap);
    logic [3:0] nib;
    logic [3:0] cmd;
    case (idx)
      2'd0:    nib = snap[3:0];
      2'd1:    nib = snap[7:4];
      2'd2:    nib = snap[11:8];
      2'd3:    nib = snap[15:12];
      default: nib = 4'h0;
    endcase
    cmd = CMD_PANEL0 + {2'b00, idx};
    return {cmd, nib};
  endfunction

endpackage

// File: rtl/rising_edge_detector.sv
// Registers a level input and flags the cycle in which it first goes high.
// Shared between the status transmitter and the command receiver.
module rising_edge_detector (
  input  logic clk,
  input  logic reset_n,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  // Remember the previous level so a new high can be told from a held one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/usb_status_transmitter.sv
// FPGA-to-PC status reporter. A request edge snapshots the four panel
// selector nibbles, then four {cmd, nibble} bytes are written into the
// FT245 FIFO after the shared data bus has been granted.
module usb_status_transmitter
  import usb_protocol_pkg::*;
#(
  parameter int SETUP_CYCLES    = DEFAULT_SETUP_CYCLES,
  parameter int WR_PULSE_CYCLES = DEFAULT_WR_PULSE_CYCLES,
  parameter int RECOVER_CYCLES  = DEFAULT_RECOVER_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        send_request,
  input  logic [15:0] panel_switches,
  input  logic        txe_n,
  input  logic        bus_grant,
  output logic        bus_request,
  output logic [7:0]  data_out,
  output logic        data_out_enable,
  output logic        wr_n,
  output logic        busy,
  output logic        done
);

  // One counter serves every timed phase; each phase stops at its own bound.
  localparam int CNT_MAX = max3(SETUP_CYCLES, WR_PULSE_CYCLES, RECOVER_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(WR_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       byte_idx_q;
  logic [15:0]      snapshot_q;
  logic             pending_q;
  logic             bus_request_q;
  logic [7:0]       data_out_q;
  logic             data_out_enable_q;
  logic             wr_n_q;
  logic             busy_q;
  logic             done_q;
  logic             start_s;

  rising_edge_detector u_req_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level_i (send_request),
    .rise_o  (start_s)
  );

  // Report sequencer: state, counters, snapshot and all outputs are registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= TX_IDLE;
      cnt_q             <= CNT_ZERO;
      byte_idx_q        <= 2'd0;
      snapshot_q        <= 16'h0000;
      pending_q         <= 1'b0;
      bus_request_q     <= 1'b0;
      data_out_q        <= 8'h00;
      data_out_enable_q <= 1'b0;
      wr_n_q            <= 1'b1;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // An edge while a report is in flight is remembered once; extra edges merge
      if (start_s && (state_q != TX_IDLE)) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        TX_IDLE: begin
          if (start_s || pending_q) begin
            state_q       <= TX_REQ;
            snapshot_q    <= panel_switches;
            pending_q     <= 1'b0;
            bus_request_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        TX_REQ: begin
          if (bus_grant) begin
            state_q           <= TX_SETUP;
            byte_idx_q        <= 2'd0;
            cnt_q             <= CNT_ZERO;
            data_out_enable_q <= 1'b1;
            data_out_q        <= panel_byte(2'd0, snapshot_q);
          end
        end
        TX_SETUP: begin
          // FIFO space is only trusted once the data setup time has elapsed
          if (cnt_q == SETUP_LAST) begin
            if (!txe_n) begin
              state_q <= TX_STROBE;
              cnt_q   <= CNT_ZERO;
              wr_n_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        TX_STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            state_q <= TX_HOLD;
            cnt_q   <= CNT_ZERO;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        TX_HOLD: begin
          if (byte_idx_q == 2'd3) begin
            state_q           <= TX_DONE;
            done_q            <= 1'b1;
            bus_request_q     <= 1'b0;
            data_out_enable_q <= 1'b0;
            data_out_q        <= 8'h00;
          end else begin
            state_q    <= TX_RECOVER;
            byte_idx_q <= byte_idx_q + 2'd1;
            cnt_q      <= CNT_ZERO;
          end
        end
        TX_RECOVER: begin
          // txe_n is still settling through its synchronizer; ignore it here
          if (cnt_q == RECOVER_LAST) begin
            state_q    <= TX_SETUP;
            cnt_q      <= CNT_ZERO;
            data_out_q <= panel_byte(byte_idx_q, snapshot_q);
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        TX_DONE: begin
          state_q <= TX_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q           <= TX_IDLE;
          cnt_q             <= CNT_ZERO;
          bus_request_q     <= 1'b0;
          data_out_q        <= 8'h00;
          data_out_enable_q <= 1'b0;
          wr_n_q            <= 1'b1;
          busy_q            <= 1'b0;
        end
      endcase
    end
  end

  assign bus_request     = bus_request_q;
  assign data_out        = data_out_q;
  assign data_out_enable = data_out_enable_q;
  assign wr_n            = wr_n_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_usb_status_transmitter.sv
// Directed bench for usb_status_transmitter with hand-computed byte values
// and strobe/done cycle numbers relative to the cycle the request edge is seen.
module tb_usb_status_transmitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        send_request;
  logic [15:0] panel_switches;
  logic        txe_n;
  logic        bus_grant;
  logic        bus_request;
  logic [7:0]  data_out;
  logic        data_out_enable;
  logic        wr_n;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int low_len  = 0;
  logic prev_wr = 1'b1;
  int st_cyc[$];
  int st_dat[$];
  int st_len[$];
  int done_cyc[$];

  always #5 clk = ~clk;

  usb_status_transmitter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .send_request    (send_request),
    .panel_switches  (panel_switches),
    .txe_n           (txe_n),
    .bus_grant       (bus_grant),
    .bus_request     (bus_request),
    .data_out        (data_out),
    .data_out_enable (data_out_enable),
    .wr_n            (wr_n),
    .busy            (busy),
    .done            (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and log strobes, done pulses and bus rules
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!wr_n && prev_wr) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(int'(data_out));
      low_len = 0;
    end
    if (!wr_n) low_len++;
    if (wr_n && !prev_wr) st_len.push_back(low_len);
    if (done) done_cyc.push_back(cyc);
    if (!data_out_enable) check_eq("data_idle_zero", {24'h0, data_out}, 32'h0);
    if (data_out_enable) check_eq("grant_held", {31'h0, bus_grant}, 32'h1);
    prev_wr = wr_n;
  endtask

  task automatic begin_report();
    st_cyc.delete();
    st_dat.delete();
    st_len.delete();
    done_cyc.delete();
    cyc = 0;
    send_request = 1'b1;
  endtask

  task automatic expect_byte(input string tag, input int k, input int start, input int dat);
    check_eq({tag, "_start"}, (k < st_cyc.size()) ? st_cyc[k] : -1, start);
    check_eq({tag, "_data"},  (k < st_dat.size()) ? st_dat[k] : -1, dat);
    check_eq({tag, "_width"}, (k < st_len.size()) ? st_len[k] : -1, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    send_request   = 1'b0;
    panel_switches = 16'hA5C3;
    txe_n          = 1'b0;
    bus_grant      = 1'b1;
    repeat (3) tick();
    check_eq("rst_bus_request", {31'h0, bus_request}, 32'h0);
    check_eq("rst_data_out", {24'h0, data_out}, 32'h0);
    check_eq("rst_oe", {31'h0, data_out_enable}, 32'h0);
    check_eq("rst_wr_n", {31'h0, wr_n}, 32'h1);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic report: grant and FIFO space already present
    begin_report();
    while (cyc < 45) begin
      tick();
      if (cyc == 2) send_request = 1'b0;
      if (cyc == 1) check_eq("t1_busreq_rise", {31'h0, bus_request}, 32'h1);
      if (cyc == 1) check_eq("t1_oe_off", {31'h0, data_out_enable}, 32'h0);
      if (cyc == 2) check_eq("t1_data_valid", {24'h0, data_out}, 32'h13);
      if (cyc == 2) check_eq("t1_oe_on", {31'h0, data_out_enable}, 32'h1);
      if (cyc == 34) check_eq("t1_busreq_hold", {31'h0, bus_request}, 32'h1);
      if (cyc == 35) check_eq("t1_busreq_drop", {31'h0, bus_request}, 32'h0);
      if (cyc == 40) check_eq("t1_busy_idle", {31'h0, busy}, 32'h0);
    end
    check_eq("t1_nbytes", st_cyc.size(), 4);
    expect_byte("t1_b0", 0, 3, 'h13);
    expect_byte("t1_b1", 1, 12, 'h2C);
    expect_byte("t1_b2", 2, 21, 'h35);
    expect_byte("t1_b3", 3, 30, 'h4A);
    check_eq("t1_ndone", done_cyc.size(), 1);
    check_eq("t1_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 35);

    // Grant withheld for ten cycles, raised during cycle 10
    bus_grant = 1'b0;
    begin_report();
    while (cyc < 55) begin
      tick();
      if (cyc == 2) send_request = 1'b0;
      if (cyc == 10) begin
        check_eq("t2_req_busreq", {31'h0, bus_request}, 32'h1);
        check_eq("t2_req_oe", {31'h0, data_out_enable}, 32'h0);
        check_eq("t2_req_wr_n", {31'h0, wr_n}, 32'h1);
        check_eq("t2_req_busy", {31'h0, busy}, 32'h1);
        bus_grant = 1'b1;
      end
    end
    expect_byte("t2_b0", 0, 12, 'h13);
    check_eq("t2_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 44);

    // FIFO full ahead of byte 2 for 20 cycles
    begin_report();
    while (cyc < 60) begin
      tick();
      if (cyc == 2) send_request = 1'b0;
      if (cyc == 17) txe_n = 1'b1;
      if (cyc == 37) txe_n = 1'b0;
      if (cyc == 30) begin
        check_eq("t3_stall_data", {24'h0, data_out}, 32'h35);
        check_eq("t3_stall_wr_n", {31'h0, wr_n}, 32'h1);
        check_eq("t3_stall_oe", {31'h0, data_out_enable}, 32'h1);
      end
    end
    expect_byte("t3_b0", 0, 3, 'h13);
    expect_byte("t3_b1", 1, 12, 'h2C);
    expect_byte("t3_b2", 2, 38, 'h35);
    expect_byte("t3_b3", 3, 47, 'h4A);
    check_eq("t3_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 52);

    // Switches change mid-report: the snapshot must hold
    begin_report();
    while (cyc < 45) begin
      tick();
      if (cyc == 2) send_request = 1'b0;
      if (cyc == 8) panel_switches = 16'hFFFF;
    end
    expect_byte("t4_b1", 1, 12, 'h2C);
    expect_byte("t4_b2", 2, 21, 'h35);
    expect_byte("t4_b3", 3, 30, 'h4A);

    // Two extra edges while busy collapse into one follow-up report
    panel_switches = 16'hA5C3;
    begin_report();
    while (cyc < 90) begin
      tick();
      if (cyc == 2)  send_request = 1'b0;
      if (cyc == 13) send_request = 1'b1;
      if (cyc == 15) send_request = 1'b0;
      if (cyc == 17) send_request = 1'b1;
      if (cyc == 19) send_request = 1'b0;
      if (cyc == 20) panel_switches = 16'h1234;
      if (cyc == 37) check_eq("t5_restart_busreq", {31'h0, bus_request}, 32'h1);
    end
    check_eq("t5_nbytes", st_cyc.size(), 8);
    check_eq("t5_ndone", done_cyc.size(), 2);
    check_eq("t5_done1", (done_cyc.size() > 1) ? done_cyc[1] : -1, 71);
    expect_byte("t5_b3", 3, 30, 'h4A);
    expect_byte("t5_r2b0", 4, 39, 'h14);
    expect_byte("t5_r2b1", 5, 48, 'h23);
    expect_byte("t5_r2b2", 6, 57, 'h32);
    expect_byte("t5_r2b3", 7, 66, 'h41);

    // Asynchronous reset in the middle of the first strobe
    begin_report();
    while (cyc < 40) begin
      tick();
      if (cyc == 2) send_request = 1'b0;
      if (cyc == 4) begin
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_wr_n", {31'h0, wr_n}, 32'h1);
        check_eq("t6_async_oe", {31'h0, data_out_enable}, 32'h0);
        check_eq("t6_async_busreq", {31'h0, bus_request}, 32'h0);
        check_eq("t6_async_busy", {31'h0, busy}, 32'h0);
      end
      if (cyc == 6) reset_n = 1'b1;
    end
    check_eq("t6_nbytes", st_cyc.size(), 1);
    check_eq("t6_ndone", done_cyc.size(), 0);
    check_eq("t6_busy_end", {31'h0, busy}, 32'h0);
    check_eq("t6_busreq_end", {31'h0, bus_request}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
